// File: rtl/decode_issue.sv
// Decode / register-read stage feeding the ALU: conditional execution, scoreboard
// stalls on in-flight register and flag writes, valid/ready output register.
module decode_issue #(
    parameter int DATA_W = 16,
    parameter int NREG   = 8,
    parameter int FCNT_W = 2
) (
    input  logic                      Clk,
    input  logic                      Reset,
    input  logic                      In_Valid,
    input  logic [15:0]               In_Instr,
    output logic                      In_Ready,
    output logic                      Out_Valid,
    input  logic                      Out_Ready,
    output logic [3:0]                Op_C,
    output logic [DATA_W-1:0]         Reg1,
    output logic [DATA_W-1:0]         Reg2,
    output logic [6:0]                Ld_Sh,
    output logic [$clog2(NREG)-1:0]   Dest,
    output logic                      Dest_En,
    input  logic                      WB_En,
    input  logic [$clog2(NREG)-1:0]   WB_Addr,
    input  logic [DATA_W-1:0]         WB_Data,
    input  logic                      Flag_En,
    input  logic [3:0]                Flag_In
);
    localparam int AW = $clog2(NREG);

    logic [DATA_W-1:0] regs_q [NREG];
    logic [DATA_W-1:0] regs_d [NREG];
    logic [NREG-1:0]   pending_q, pending_d;
    logic [3:0]        flags_q, flags_d;
    logic [FCNT_W-1:0] fcnt_q, fcnt_d;

    logic              out_valid_q, out_valid_d;
    logic [3:0]        op_q, op_d;
    logic [DATA_W-1:0] reg1_q, reg1_d, reg2_q, reg2_d;
    logic [6:0]        ld_sh_q, ld_sh_d;
    logic [AW-1:0]     dest_q, dest_d;
    logic              dest_en_q, dest_en_d;

    logic [1:0]    cond;
    logic [3:0]    opc;
    logic [AW-1:0] ra, rb, dest_idx;
    logic          use1, use2, has_dest, flag_wr, cond_pass;
    logic          stall, issue, fcnt_inc;
    logic          unused_flag_v;

    assign unused_flag_v = flags_q[0];

    always_comb begin
        cond     = In_Instr[15:14];
        opc      = In_Instr[13:10];
        ra       = In_Instr[9:7];
        rb       = In_Instr[6:4];
        use1     = !(opc == 4'b0110 || opc == 4'b1100 || opc == 4'b1111);
        use2     = (opc <= 4'b0101) || opc == 4'b0111 || opc == 4'b1011 || opc == 4'b1110;
        has_dest = !(opc == 4'b1011 || opc == 4'b1110 || opc == 4'b1111);
        dest_idx = (opc == 4'b1101) ? rb : ra;
        flag_wr  = (opc <= 4'b0101) || opc == 4'b1011;
        case (cond)
            2'b00:   cond_pass = 1'b1;
            2'b01:   cond_pass = flags_q[2];
            2'b10:   cond_pass = flags_q[3];
            default: cond_pass = flags_q[1];
        endcase
    end

    // Hazard check looks only at registered state; same-cycle writebacks cost one bubble.
    always_comb begin
        stall = (out_valid_q && !Out_Ready)
              || (use1 && pending_q[ra])
              || (use2 && pending_q[rb])
              || (has_dest && pending_q[dest_idx])
              || (cond != 2'b00 && fcnt_q != '0)
              || (flag_wr && fcnt_q == '1);
        In_Ready = !stall;
        issue    = In_Valid && !stall;
        fcnt_inc = issue && cond_pass && flag_wr;
    end

    always_comb begin
        regs_d    = regs_q;
        pending_d = pending_q;
        flags_d   = flags_q;
        fcnt_d    = fcnt_q;
        if (WB_En) begin
            regs_d[WB_Addr]    = WB_Data;
            pending_d[WB_Addr] = 1'b0;
        end
        if (issue && cond_pass && has_dest)
            pending_d[dest_idx] = 1'b1;
        if (Flag_En)
            flags_d = Flag_In;
        if (fcnt_inc && !Flag_En)
            fcnt_d = fcnt_q + 1'b1;
        else if (!fcnt_inc && Flag_En && fcnt_q != '0)
            fcnt_d = fcnt_q - 1'b1;
    end

    always_comb begin
        out_valid_d = out_valid_q;
        op_d        = op_q;
        reg1_d      = reg1_q;
        reg2_d      = reg2_q;
        ld_sh_d     = ld_sh_q;
        dest_d      = dest_q;
        dest_en_d   = dest_en_q;
        if (issue) begin
            out_valid_d = 1'b1;
            op_d        = cond_pass ? opc : 4'b1111;
            reg1_d      = regs_d[ra];
            reg2_d      = regs_d[rb];
            ld_sh_d     = In_Instr[6:0];
            dest_d      = dest_idx;
            dest_en_d   = cond_pass && has_dest;
        end else if (Out_Ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            regs_q      <= '{default: '0};
            pending_q   <= '0;
            flags_q     <= '0;
            fcnt_q      <= '0;
            out_valid_q <= 1'b0;
            op_q        <= 4'b1111;
            reg1_q      <= '0;
            reg2_q      <= '0;
            ld_sh_q     <= '0;
            dest_q      <= '0;
            dest_en_q   <= 1'b0;
        end else begin
            regs_q      <= regs_d;
            pending_q   <= pending_d;
            flags_q     <= flags_d;
            fcnt_q      <= fcnt_d;
            out_valid_q <= out_valid_d;
            op_q        <= op_d;
            reg1_q      <= reg1_d;
            reg2_q      <= reg2_d;
            ld_sh_q     <= ld_sh_d;
            dest_q      <= dest_d;
            dest_en_q   <= dest_en_d;
        end
    end

    assign Out_Valid = out_valid_q;
    assign Op_C      = op_q;
    assign Reg1      = reg1_q;
    assign Reg2      = reg2_q;
    assign Ld_Sh     = ld_sh_q;
    assign Dest      = dest_q;
    assign Dest_En   = dest_en_q;

endmodule
